// File: rtl/led_display_arbiter.sv
// LED bank arbiter: the safety alert preempts, while GPS and navigation share the bank round-robin with a minimum dwell.
// Optional alert blinking is enabled by defining ALERT_BLINK_EN.
module led_display_arbiter #(
    parameter int HOLD_CYCLES  = 25000000,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alert_req,
    input  logic [7:0] alert_data,
    input  logic       gps_req,
    input  logic [7:0] gps_data,
    input  logic       nav_req,
    input  logic [7:0] nav_data,
    output logic [7:0] led_out,
    output logic [2:0] grant,
    output logic       hold_done
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 2) begin : g_hold_check
        $error("HOLD_CYCLES must be at least 2");
    end
    if (BLINK_CYCLES < 2) begin : g_blink_check
        $error("BLINK_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ALERT = 2'd2
    } state_t;

    typedef enum logic {
        SRC_GPS = 1'b0,
        SRC_NAV = 1'b1
    } src_t;

    state_t            state, state_nx;
    src_t              src, src_nx;
    src_t              rr_ptr, rr_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;

    logic       own_req;
    logic       other_req;
    src_t       other_src;

    logic [2:0] grant_nx;
    logic [7:0] led_nx;
    logic       hold_done_nx;

    assign own_req   = (src == SRC_GPS) ? gps_req : nav_req;
    assign other_req = (src == SRC_GPS) ? nav_req : gps_req;
    assign other_src = (src == SRC_GPS) ? SRC_NAV : SRC_GPS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            src      <= SRC_GPS;
            rr_ptr   <= SRC_GPS;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            src      <= src_nx;
            rr_ptr   <= rr_nx;
            hold_cnt <= hold_nx;
        end
    end

    // The rr pointer always names the source that wins the next contended arbitration.
    always_comb begin
        state_nx = state;
        src_nx   = src;
        rr_nx    = rr_ptr;
        hold_nx  = hold_cnt;
        case (state)
            IDLE: begin
                hold_nx = '0;
                if (alert_req) begin
                    state_nx = ALERT;
                end else if (gps_req && nav_req) begin
                    state_nx = SERVE;
                    src_nx   = rr_ptr;
                end else if (gps_req) begin
                    state_nx = SERVE;
                    src_nx   = SRC_GPS;
                end else if (nav_req) begin
                    state_nx = SERVE;
                    src_nx   = SRC_NAV;
                end
            end
            SERVE: begin
                if (alert_req) begin
                    state_nx = ALERT;
                    hold_nx  = '0;
                end else if (!own_req) begin
                    rr_nx   = other_src;
                    hold_nx = '0;
                    if (other_req) begin
                        src_nx = other_src;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if ((hold_cnt == HOLD_MAX) && other_req) begin
                    src_nx  = other_src;
                    rr_nx   = other_src;
                    hold_nx = '0;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            ALERT: begin
                hold_nx = '0;
                if (!alert_req) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                hold_nx  = '0;
            end
        endcase
    end

`ifdef ALERT_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CYCLES - 1);

    logic [BLINK_W-1:0] blink_cnt, blink_cnt_nx;
    logic               blink_on, blink_on_nx;

    // Blink phase restarts "on" at every alert entry.
    always_comb begin
        blink_cnt_nx = '0;
        blink_on_nx  = 1'b1;
        if ((state_nx == ALERT) && (state == ALERT)) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_on_nx = ~blink_on;
            end else begin
                blink_cnt_nx = blink_cnt + 1'b1;
                blink_on_nx  = blink_on;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            blink_cnt <= blink_cnt_nx;
            blink_on  <= blink_on_nx;
        end
    end
`endif

    always_comb begin
        grant_nx     = 3'b000;
        led_nx       = 8'h00;
        hold_done_nx = 1'b0;
        case (state_nx)
            ALERT: begin
                grant_nx = 3'b001;
`ifdef ALERT_BLINK_EN
                led_nx   = blink_on_nx ? alert_data : 8'h00;
`else
                led_nx   = alert_data;
`endif
            end
            SERVE: begin
                grant_nx     = (src_nx == SRC_GPS) ? 3'b010 : 3'b100;
                led_nx       = (src_nx == SRC_GPS) ? gps_data : nav_data;
                hold_done_nx = (hold_nx == HOLD_MAX);
            end
            default: begin
                grant_nx = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out   <= 8'h00;
            grant     <= 3'b000;
            hold_done <= 1'b0;
        end else begin
            led_out   <= led_nx;
            grant     <= grant_nx;
            hold_done <= hold_done_nx;
        end
    end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Self-checking bench for led_display_arbiter with HOLD_CYCLES=8, BLINK_CYCLES=4.
// Directed scenarios plus randomized traffic against a bank-ownership reference model.
module tb_led_display_arbiter;

    localparam int HOLD  = 8;
    localparam int BLINK = 4;

    localparam int OWN_NONE  = 0;
    localparam int OWN_ALERT = 1;
    localparam int OWN_GPS   = 2;
    localparam int OWN_NAV   = 3;

    logic       clk;
    logic       rst;
    logic       alert_req;
    logic [7:0] alert_data;
    logic       gps_req;
    logic [7:0] gps_data;
    logic       nav_req;
    logic [7:0] nav_data;
    logic [7:0] led_out;
    logic [2:0] grant;
    logic       hold_done;

    int checks;
    int errors;

    // Reference model: who owns the bank, how long they have shown, who wins a tie
    int owner;
    int favour;
    int dwell;
    int age;
    logic [7:0] exp_led;
    logic [2:0] exp_grant;
    logic       exp_done;

    led_display_arbiter #(
        .HOLD_CYCLES (HOLD),
        .BLINK_CYCLES(BLINK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alert_req (alert_req),
        .alert_data(alert_data),
        .gps_req   (gps_req),
        .gps_data  (gps_data),
        .nav_req   (nav_req),
        .nav_data  (nav_data),
        .led_out   (led_out),
        .grant     (grant),
        .hold_done (hold_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        owner     = OWN_NONE;
        favour    = OWN_GPS;
        dwell     = 0;
        age       = 0;
        exp_led   = 8'h00;
        exp_grant = 3'b000;
        exp_done  = 1'b0;
    endtask

    task automatic model_edge();
        int  nxt;
        int  oth;
        bit  own_r;
        bit  oth_r;
        if (rst) begin
            model_reset();
        end else begin
            nxt = owner;
            if (alert_req) begin
                age = (owner == OWN_ALERT) ? age + 1 : 0;
                nxt = OWN_ALERT;
            end else if (owner == OWN_ALERT) begin
                nxt = OWN_NONE;
            end else if (owner == OWN_NONE) begin
                if (gps_req && nav_req) nxt = favour;
                else if (gps_req)       nxt = OWN_GPS;
                else if (nav_req)       nxt = OWN_NAV;
                dwell = 1;
            end else begin
                oth   = (owner == OWN_GPS) ? OWN_NAV : OWN_GPS;
                own_r = (owner == OWN_GPS) ? gps_req : nav_req;
                oth_r = (owner == OWN_GPS) ? nav_req : gps_req;
                if (!own_r) begin
                    favour = oth;
                    nxt    = oth_r ? oth : OWN_NONE;
                    dwell  = 1;
                end else if (dwell >= HOLD && oth_r) begin
                    nxt    = oth;
                    favour = oth;
                    dwell  = 1;
                end else begin
                    dwell = dwell + 1;
                end
            end
            owner = nxt;
            exp_done = 1'b0;
            case (owner)
                OWN_ALERT: begin
                    exp_grant = 3'b001;
`ifdef ALERT_BLINK_EN
                    exp_led = (((age / BLINK) % 2) == 0) ? alert_data : 8'h00;
`else
                    exp_led = alert_data;
`endif
                end
                OWN_GPS: begin
                    exp_grant = 3'b010;
                    exp_led   = gps_data;
                    exp_done  = (dwell >= HOLD);
                end
                OWN_NAV: begin
                    exp_grant = 3'b100;
                    exp_led   = nav_data;
                    exp_done  = (dwell >= HOLD);
                end
                default: begin
                    exp_grant = 3'b000;
                    exp_led   = 8'h00;
                end
            endcase
        end
    endtask

    // One active edge: the model consumes the inputs the DUT sampled, outputs are read 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        alert_req = 1'b0;
        gps_req   = 1'b0;
        nav_req   = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        alert_req  = 1'b0;
        gps_req    = 1'b0;
        nav_req    = 1'b0;
        alert_data = 8'h00;
        gps_data   = 8'h00;
        nav_data   = 8'h00;
        #1;
        rst = 1'b1;
        #2;
        model_reset();
        checks++;
        if (led_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_led: led_out=%h expected 00", led_out);
        end
        checks++;
        if (grant !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_grant: grant=%b expected 000", grant);
        end
        checks++;
        if (hold_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold_done: hold_done=%b expected 0", hold_done);
        end
        tick();
        tick();
        #2;
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 3'b000 || led_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: grant=%b led_out=%h expected 000/00", grant, led_out);
        end
    endtask

    task automatic test_single_grant();
        gps_data = 8'h0C;
        gps_req  = 1'b1;
        tick();
        checks++;
        if (grant !== 3'b010 || led_out !== 8'h0C) begin
            errors++;
            $display("[TB] FAIL single_gps: grant=%b led_out=%h expected 010/0c", grant, led_out);
        end
        gps_data = 8'h3C;
        tick();
        checks++;
        if (led_out !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL follow_data: led_out=%h expected 3c", led_out);
        end
        gps_req = 1'b0;
        tick();
        checks++;
        if (grant !== 3'b000 || led_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL gps_release: grant=%b led_out=%h expected 000/00", grant, led_out);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] want_grant;
        logic [7:0] want_led;
        logic       want_done;
        reset_dut();
        gps_data = 8'h0C;
        nav_data = 8'hA5;
        gps_req  = 1'b1;
        nav_req  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            want_grant = (((k / HOLD) % 2) == 0) ? 3'b010 : 3'b100;
            want_led   = (((k / HOLD) % 2) == 0) ? 8'h0C : 8'hA5;
            want_done  = ((k % HOLD) == HOLD - 1);
            checks++;
            if (grant !== want_grant || led_out !== want_led || hold_done !== want_done) begin
                errors++;
                $display("[TB] FAIL round_robin cycle %0d: grant=%b led_out=%h hold_done=%b expected %b/%h/%b",
                         k, grant, led_out, hold_done, want_grant, want_led, want_done);
            end
        end
    endtask

    task automatic test_alert_preempt();
        reset_dut();
        gps_data = 8'h0C;
        gps_req  = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (grant !== 3'b010 || hold_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL preempt_setup: grant=%b hold_done=%b expected 010/0", grant, hold_done);
        end
        alert_data = 8'hFF;
        alert_req  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (grant !== 3'b001 || led_out !== 8'hFF || hold_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL alert_show cycle %0d: grant=%b led_out=%h hold_done=%b expected 001/ff/0",
                         k, grant, led_out, hold_done);
            end
        end
        alert_req = 1'b0;
        tick();
        checks++;
        if (grant !== 3'b000 || led_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL alert_exit_idle: grant=%b led_out=%h expected 000/00", grant, led_out);
        end
        tick();
        checks++;
        if (grant !== 3'b010 || led_out !== 8'h0C || hold_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gps_regrant: grant=%b led_out=%h hold_done=%b expected 010/0c/0",
                     grant, led_out, hold_done);
        end
        for (int k = 1; k < HOLD; k++) begin
            tick();
            checks++;
            if (hold_done !== (k == HOLD - 1)) begin
                errors++;
                $display("[TB] FAIL regrant_hold cycle %0d: hold_done=%b expected %b", k, hold_done, (k == HOLD - 1));
            end
        end
        gps_req = 1'b0;
        tick();
    endtask

    task automatic test_drop_switch();
        reset_dut();
        gps_data = 8'h0C;
        nav_data = 8'hA5;
        gps_req  = 1'b1;
        nav_req  = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (grant !== 3'b010) begin
            errors++;
            $display("[TB] FAIL drop_setup: grant=%b expected 010", grant);
        end
        gps_req = 1'b0;
        tick();
        checks++;
        if (grant !== 3'b100 || led_out !== 8'hA5 || hold_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_switch: grant=%b led_out=%h hold_done=%b expected 100/a5/0",
                     grant, led_out, hold_done);
        end
        for (int k = 1; k < HOLD; k++) begin
            tick();
            checks++;
            if (grant !== 3'b100 || hold_done !== (k == HOLD - 1)) begin
                errors++;
                $display("[TB] FAIL drop_hold cycle %0d: grant=%b hold_done=%b expected 100/%b",
                         k, grant, hold_done, (k == HOLD - 1));
            end
        end
        nav_req = 1'b0;
        tick();
    endtask

    task automatic test_blink();
        logic [7:0] want;
        reset_dut();
        alert_data = 8'h81;
        alert_req  = 1'b1;
        for (int k = 0; k < 4 * BLINK; k++) begin
            tick();
`ifdef ALERT_BLINK_EN
            want = (((k / BLINK) % 2) == 0) ? 8'h81 : 8'h00;
`else
            want = 8'h81;
`endif
            checks++;
            if (grant !== 3'b001 || led_out !== want) begin
                errors++;
                $display("[TB] FAIL alert_pattern cycle %0d: grant=%b led_out=%h expected 001/%h",
                         k, grant, led_out, want);
            end
        end
    endtask

    task automatic test_reset_mid_alert();
        rst = 1'b1;
        #2;
        model_reset();
        checks++;
        if (led_out !== 8'h00 || grant !== 3'b000 || hold_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: led_out=%h grant=%b hold_done=%b expected 00/000/0",
                     led_out, grant, hold_done);
        end
        alert_req = 1'b0;
        gps_data  = 8'h0C;
        nav_data  = 8'hA5;
        gps_req   = 1'b1;
        nav_req   = 1'b1;
        tick();
        checks++;
        if (grant !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_held: grant=%b expected 000", grant);
        end
        #2;
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 3'b010 || led_out !== 8'h0C) begin
            errors++;
            $display("[TB] FAIL fresh_after_reset: grant=%b led_out=%h expected 010/0c", grant, led_out);
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int k = 0; k < 3000; k++) begin
            if (alert_req) begin
                if ($urandom_range(0, 5) == 0) alert_req = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                alert_req = 1'b1;
            end
            if ($urandom_range(0, 11) == 0) gps_req = ~gps_req;
            if ($urandom_range(0, 11) == 0) nav_req = ~nav_req;
            alert_data = 8'($urandom);
            gps_data   = 8'($urandom);
            nav_data   = 8'($urandom);
            tick();
            checks++;
            if (grant !== exp_grant || led_out !== exp_led || hold_done !== exp_done) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: grant=%b led_out=%h hold_done=%b expected %b/%h/%b",
                         k, grant, led_out, hold_done, exp_grant, exp_led, exp_done);
            end
            checks++;
            if (!$onehot0(grant)) begin
                errors++;
                $display("[TB] FAIL grant_onehot cycle %0d: grant=%b expected at most one bit", k, grant);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_alert_preempt();
        test_drop_switch();
        test_blink();
        test_reset_mid_alert();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
